// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready pipeline register with optional 2-entry skid buffer, flush and perf counters
// Ports: clk/rst (sync, active-high); flush kills held entries;
//   in_valid/in_ready/in_data upstream; out_valid/out_ready/out_data downstream (NOP_VALUE when idle);
//   occupancy = held entries; bubble_cnt/hold_cnt saturating counts of idle and stalled cycles.
module pipe_stage_buf #(
  parameter int DATA_W = 81,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter int SKID = 1,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  hold_cnt
);
  logic              m_v_q, m_v_d, s_v_q, s_v_d;
  logic [DATA_W-1:0] m_d_q, m_d_d, s_d_q, s_d_d;
  logic [CNT_W-1:0]  bubble_q, bubble_d, hold_q, hold_d;
  logic              acc, fire;
  // With SKID=0 the skid entry never fills, so the shared next-state logic
  // reduces exactly to the single-register behaviour.
  assign in_ready   = (SKID != 0) ? !s_v_q : (!m_v_q || out_ready);
  assign acc        = in_valid && in_ready;
  assign fire       = m_v_q && out_ready;
  assign out_valid  = m_v_q;
  assign out_data   = m_v_q ? m_d_q : NOP_VALUE;
  assign occupancy  = 2'(m_v_q) + 2'(s_v_q);
  assign bubble_cnt = bubble_q;
  assign hold_cnt   = hold_q;
  always_comb begin
    m_v_d    = !flush && (acc || s_v_q || (m_v_q && !out_ready));
    m_d_d    = (!m_v_q || (fire && !s_v_q)) ? in_data : (fire ? s_d_q : m_d_q);
    s_v_d    = (SKID != 0) && !flush && (s_v_q ? !fire : (acc && m_v_q && !out_ready));
    s_d_d    = s_v_q ? s_d_q : in_data;
    bubble_d = (!m_v_q && !(&bubble_q)) ? bubble_q + CNT_W'(1) : bubble_q;
    hold_d   = (m_v_q && !out_ready && !(&hold_q)) ? hold_q + CNT_W'(1) : hold_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      m_v_q    <= 1'b0;
      s_v_q    <= 1'b0;
      m_d_q    <= '0;
      s_d_q    <= '0;
      bubble_q <= '0;
      hold_q   <= '0;
    end else begin
      m_v_q    <= m_v_d;
      s_v_q    <= s_v_d;
      m_d_q    <= m_d_d;
      s_d_q    <= s_d_d;
      bubble_q <= bubble_d;
      hold_q   <= hold_d;
    end
  end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed scoreboard bench for skid, combinational-ready and saturating-counter configs
module tb_pipe_stage_buf;
  localparam logic [15:0] NOP = 16'hDEAD;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic        a_fl = 0, a_iv = 0, a_or = 0, a_ir, a_ov;
  logic [15:0] a_id = 0, a_od;
  logic [1:0]  a_occ;
  logic [31:0] a_bub, a_hold;
  logic        b_fl = 0, b_iv = 0, b_or = 0, b_ir, b_ov;
  logic [15:0] b_id = 0, b_od;
  logic [1:0]  b_occ;
  logic [31:0] b_bub, b_hold;
  logic        c_ir, c_ov;
  logic [15:0] c_od;
  logic [1:0]  c_occ;
  logic [2:0]  c_bub, c_hold;
  logic [15:0] qa[$], qb[$];
  int checks = 0, errors = 0;
  pipe_stage_buf #(.DATA_W(16), .NOP_VALUE(NOP), .SKID(1), .CNT_W(32)) u_a (
    .clk(clk), .rst(rst), .flush(a_fl), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .occupancy(a_occ),
    .bubble_cnt(a_bub), .hold_cnt(a_hold));
  pipe_stage_buf #(.DATA_W(16), .NOP_VALUE(NOP), .SKID(0), .CNT_W(32)) u_b (
    .clk(clk), .rst(rst), .flush(b_fl), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .occupancy(b_occ),
    .bubble_cnt(b_bub), .hold_cnt(b_hold));
  pipe_stage_buf #(.DATA_W(16), .NOP_VALUE(NOP), .SKID(1), .CNT_W(3)) u_c (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(1'b0), .in_ready(c_ir), .in_data(16'h0),
    .out_valid(c_ov), .out_ready(1'b1), .out_data(c_od), .occupancy(c_occ),
    .bubble_cnt(c_bub), .hold_cnt(c_hold));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic set_a(input logic iv, input logic [15:0] d, input logic ordy, input logic fl);
    a_iv = iv; a_id = d; a_or = ordy; a_fl = fl; #1;
  endtask
  task automatic set_b(input logic iv, input logic [15:0] d, input logic ordy);
    b_iv = iv; b_id = d; b_or = ordy; #1;
  endtask
  task automatic take(input string tag, inout logic [15:0] q[$], input logic [15:0] od);
    checks++;
    assert (q.size() != 0) else begin
      errors++;
      $error("FAIL %s observed=%h expected=<none>", tag, od);
    end
    if (q.size() != 0) chk(tag, 32'(od), 32'(q.pop_front()));
  endtask
  task automatic adv();
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      if (a_ov && a_or) take("a_order", qa, a_od);
      if (a_fl) qa.delete();
      else if (a_iv && a_ir) qa.push_back(a_id);
      if (b_ov && b_or) take("b_order", qb, b_od);
      if (b_iv && b_ir) qb.push_back(b_id);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov", 32'(a_ov), 0);
    chk("rst_od", 32'(a_od), 32'(NOP));
    chk("rst_occ", 32'(a_occ), 0);
    chk("rst_bub", a_bub, 0);
    chk("rst_hold", a_hold, 0);
    chk("rst_ir_a", 32'(a_ir), 1);
    chk("rst_ir_b", 32'(b_ir), 1);
    rst = 0;
    set_a(1, 16'h1, 1, 0); adv();
    chk("st_occ1", 32'(a_occ), 1);
    chk("st_od1", 32'(a_od), 32'h1);
    set_a(1, 16'h2, 1, 0); adv();
    chk("st_occ2", 32'(a_occ), 1);
    set_a(1, 16'h3, 1, 0); adv();
    chk("st_occ3", 32'(a_occ), 1);
    set_a(0, 16'h0, 1, 0); adv();
    chk("st_hold", a_hold, 0);
    chk("st_bub", a_bub, 1);
    chk("st_empty", 32'(a_ov), 0);
    set_a(1, 16'hA, 1, 0); adv();
    set_a(1, 16'hB, 0, 0);
    chk("sk_ir_open", 32'(a_ir), 1);
    adv();
    set_a(1, 16'hC, 0, 0);
    chk("sk_ir_full", 32'(a_ir), 0);
    chk("sk_occ2", 32'(a_occ), 2);
    chk("sk_od_a", 32'(a_od), 32'hA);
    chk("sk_hold1", a_hold, 1);
    adv();
    chk("sk_hold2", a_hold, 2);
    chk("sk_ir_still", 32'(a_ir), 0);
    adv();
    chk("sk_hold3", a_hold, 3);
    set_a(1, 16'hC, 1, 0); adv();
    chk("sk_ir_back", 32'(a_ir), 1);
    chk("sk_od_b", 32'(a_od), 32'hB);
    chk("sk_occ1", 32'(a_occ), 1);
    adv();
    chk("sk_od_c", 32'(a_od), 32'hC);
    set_a(0, 16'h0, 1, 0); adv();
    chk("sk_hold_end", a_hold, 3);
    chk("sk_bub", a_bub, 2);
    set_a(1, 16'h11, 0, 0); adv();
    set_a(1, 16'h22, 0, 0); adv();
    chk("fl_occ2", 32'(a_occ), 2);
    set_a(1, 16'h33, 0, 1); adv();
    set_a(0, 16'h0, 1, 0);
    chk("fl_ov", 32'(a_ov), 0);
    chk("fl_od", 32'(a_od), 32'(NOP));
    chk("fl_occ", 32'(a_occ), 0);
    chk("fl_ir", 32'(a_ir), 1);
    adv();
    chk("fl_ov_after", 32'(a_ov), 0);
    set_a(1, 16'h99, 1, 1); adv();
    set_a(0, 16'h0, 1, 0);
    chk("fl_acc_drop", 32'(a_ov), 0);
    set_b(1, 16'h5, 0);
    chk("m0_ir_empty", 32'(b_ir), 1);
    adv();
    set_b(1, 16'h6, 0);
    chk("m0_ir_stall", 32'(b_ir), 0);
    chk("m0_occ", 32'(b_occ), 1);
    adv();
    chk("m0_held", 32'(b_od), 32'h5);
    set_b(1, 16'h6, 1);
    chk("m0_ir_pass", 32'(b_ir), 1);
    adv();
    chk("m0_b2b", 32'(b_od), 32'h6);
    set_b(1, 16'h7, 1); adv();
    chk("m0_od7", 32'(b_od), 32'h7);
    set_b(0, 16'h0, 1); adv();
    chk("m0_occ0", 32'(b_occ), 0);
    chk("m0_od_nop", 32'(b_od), 32'(NOP));
    set_a(1, 16'h44, 0, 0); adv();
    set_a(1, 16'h55, 0, 0); adv();
    chk("rs_pre_occ", 32'(a_occ), 2);
    set_a(0, 16'h0, 0, 0);
    rst = 1; adv();
    chk("rs_ov", 32'(a_ov), 0);
    chk("rs_od", 32'(a_od), 32'(NOP));
    chk("rs_occ", 32'(a_occ), 0);
    chk("rs_bub", a_bub, 0);
    chk("rs_hold", a_hold, 0);
    chk("rs_ir", 32'(a_ir), 1);
    chk("rs_c_bub", 32'(c_bub), 0);
    rst = 0;
    repeat (6) adv();
    chk("sat_c6", 32'(c_bub), 6);
    adv();
    chk("sat_c7", 32'(c_bub), 7);
    repeat (3) adv();
    chk("sat_c10", 32'(c_bub), 7);
    chk("sat_hold", 32'(c_hold), 0);
    chk("qa_empty", 32'(qa.size()), 0);
    chk("qb_empty", 32'(qb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline-stage register, the generalised successor of the fixed-field ID/EX latch. It carries an opaque DATA_W-bit payload (default: packed aluop/alusel/reg1/reg2/wd/wreg) between any two pipeline stages. It uses a valid/ready handshake instead of a global stall vector, and supports synchronous flush and bubble insertion. It optionally includes a 2-entry skid buffer so that ready is fully registered, plus saturating bubble and hold performance counters.

## Interface
- DATA_W, 81, payload width in bits.
- NOP_VALUE, 0, payload driven on out_data whenever out_valid=0 (bubble encoding).
- SKID, 1, selects the buffer mode: 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 32, width of the performance counters.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  payload presented downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  downstream payload; equals NOP_VALUE when out_valid=0.
- occupancy  out  2  entries held (0..2; max 1 when SKID=0).
- bubble_cnt  out  CNT_W  cycles with out_valid=0 since reset; saturating.
- hold_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturating.

## Operation
- **Handshake terms:** an input transfer (acc) occurs when in_valid && in_ready. An output transfer (fire) occurs when out_valid && out_ready.
- **Main entry M:** M always drives the output, so out_valid = M.v and out_data = M.v ? M.d : NOP_VALUE.
- **SKID=1:** adds a skid entry S; in_ready = !S.v, taken from a register. Per clock edge, with no flush:
  - M empty, acc: M <= in.
  - M full, fire, S empty, acc: M <= in.
  - M full, fire, S full: M <= S, S cleared. No acc is possible because in_ready=0.
  - M full, fire, no acc, S empty: M cleared.
  - M full, no fire, acc: S <= in.
  - Otherwise: hold.
- **SKID=0:** in_ready = !M.v || out_ready, computed combinationally. On acc, M <= in. On fire without acc, M cleared. Otherwise hold.
- **Ordering:** payloads leave in exactly the order they were accepted. None are lost, none are duplicated.
- **Flush:** takes priority over everything else. M.v and S.v clear at the edge. A payload offered in the flush cycle counts as accepted if in_ready=1, and is then discarded. The downstream side still sees fire for the current M in that cycle. Counters are not cleared by flush.
- **Counters:** bubble_cnt and hold_cnt each increment by 1 on every non-reset edge where their condition held in the preceding cycle. Each stops at 2^CNT_W-1 and does not wrap.
- **occupancy:** equals M.v + S.v.

## Timing
- **Reset values:** M.v=0 and S.v=0, so out_valid=0, out_data=NOP_VALUE, occupancy=0, bubble_cnt=0 and hold_cnt=0. in_ready is 1 in both modes.
- **Latency:** 1 cycle. An acc at edge N makes out_valid=1 after edge N.
- **Throughput:** 1 payload/cycle in both modes while out_ready=1.
- **SKID=1 backpressure:** absorbs exactly one extra payload after out_ready drops. in_ready falls on the edge after S fills, and rises on the edge after S drains.
- **Reset during operation:** all held payloads are dropped. Outputs return to their reset values on the next edge.

## Test plan
- **Streaming:** SKID=1, out_ready=1, inputs 0x1,0x2,0x3 on consecutive cycles. Expect out_data 0x1,0x2,0x3 on the following three cycles, occupancy=1 throughout, and hold_cnt=0.
- **Skid fill:** SKID=1, drop out_ready while streaming 0xA,0xB,0xC.
  - 0xA holds on the output and 0xB lands in S.
  - in_ready goes 0 and 0xC is held upstream.
  - occupancy=2, and hold_cnt increments each stalled cycle.
  - Release out_ready: order 0xA,0xB,0xC with no gap.
- **Mode 0 combinational ready:** SKID=0, M full, out_ready=0. Expect in_ready=0 in the same cycle. With out_ready=1, expect in_ready=1 and replacement of M in the same edge (back-to-back).
- **Flush with both entries full:** flush=1 for one cycle with in_valid=1. Expect out_valid=0, out_data=NOP_VALUE and occupancy=0 at the next edge, and the input payload not to appear on the output.
- **Reset and saturation:**
  - rst mid-stream: all outputs take their reset values after one edge.
  - CNT_W=3 with out_valid=0 for 10 cycles: bubble_cnt stops at 7.
